pipe_divider: RTL and testbench

PIPE_DIVIDER -- requirements
Module: pipe_divider

---
 rtl/div_pkg.sv | 27 ++
 rtl/div_stage.sv | 35 +++
 rtl/pipe_divider.sv | 119 +++++++++++
 tb/tb_pipe_divider.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants, stage payload layout and configuration check for the
// pipelined restoring divider.
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_STAGES = 8;

  // Layout of one pipeline slice at the default width; pipe_divider resizes
  // the same fields to its WIDTH parameter.
  typedef struct packed {
    logic                 valid;
    logic [DIV_WIDTH-1:0] a_mag;
    logic [DIV_WIDTH-1:0] b_mag;
    logic [DIV_WIDTH-1:0] q;
    logic [DIV_WIDTH-1:0] r;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dbz;
  } div_payload_t;

  function automatic bit div_cfg_ok(input int width, input int stages);
    return (stages > 0) && (width > 0) && ((width % stages) == 0);
  endfunction

  localparam bit DIV_DEFAULT_CFG_OK = div_cfg_ok(DIV_WIDTH, DIV_STAGES);

endpackage

// File: rtl/div_stage.sv
// Combinational slice of the restoring divider: resolves BITS quotient bits,
// MSB first, starting at quotient bit LSB+BITS-1.
module div_stage #(
  parameter int WIDTH = 32,
  parameter int BITS  = 4,
  parameter int LSB   = 28
) (
  input  logic [BITS-1:0]  a_bits,
  input  logic [WIDTH-1:0] b_mag,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] r_in,
  output logic [WIDTH-1:0] q_out,
  output logic [WIDTH-1:0] r_out
);

  logic [WIDTH:0]   r_work;
  logic [WIDTH-1:0] q_work;

  // The incoming remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and one conditional subtract restores it.
  always_comb begin
    r_work = {1'b0, r_in};
    q_work = q_in;
    for (int i = BITS - 1; i >= 0; i--) begin
      r_work = {r_work[WIDTH-1:0], a_bits[i]};
      if (r_work >= {1'b0, b_mag}) begin
        r_work            = r_work - {1'b0, b_mag};
        q_work[LSB + i]   = 1'b1;
      end
    end
    q_out = q_work;
    r_out = r_work[WIDTH-1:0];
  end

endmodule

// File: rtl/pipe_divider.sv
// Pipelined divider: STAGES register slices, each fed by one div_stage; sign
// pre-negation sits in front of slice 0 and sign/zero fixup after the last.
module pipe_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter int STAGES    = DIV_STAGES,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_div_by_zero
);

  localparam int BITS = WIDTH / STAGES;

  if (!DIV_DEFAULT_CFG_OK || !div_cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
    $error("pipe_divider: WIDTH must be an integer multiple of STAGES");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;
  } stage_t;

  stage_t stage_q [STAGES];
  stage_t stage_d [STAGES];
  stage_t src     [STAGES];
  stage_t in_pkt;
  logic   en;
  logic   op_signed;
  logic   a_neg;
  logic   b_neg;
  logic   b_zero;
  logic [WIDTH-1:0] rem_mag;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    op_signed    = SIGNED_EN && in_signed;
    a_neg        = op_signed && in_dividend[WIDTH-1];
    b_neg        = op_signed && in_divisor[WIDTH-1];
    b_zero       = (in_divisor == '0);
    in_pkt       = '0;
    in_pkt.valid = in_valid && in_ready;
    in_pkt.a_mag = a_neg ? -in_dividend : in_dividend;
    in_pkt.b_mag = b_neg ? -in_divisor : in_divisor;
    in_pkt.neg_q = (a_neg ^ b_neg) && !b_zero;
    in_pkt.neg_r = a_neg;
    in_pkt.dbz   = b_zero;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] r_next;

    if (k == 0) begin : g_head
      assign src[k] = in_pkt;
    end else begin : g_body
      assign src[k] = stage_q[k-1];
    end

    div_stage #(
      .WIDTH(WIDTH),
      .BITS (BITS),
      .LSB  (WIDTH - (k + 1) * BITS)
    ) u_div_stage (
      .a_bits(src[k].a_mag[WIDTH-(k+1)*BITS +: BITS]),
      .b_mag (src[k].b_mag),
      .q_in  (src[k].q),
      .r_in  (src[k].r),
      .q_out (q_next),
      .r_out (r_next)
    );

    // Bubbles travel as all-zero payloads so idle slices never carry stale flags.
    assign stage_d[k] = src[k].valid
      ? stage_t'{valid: 1'b1, a_mag: src[k].a_mag, b_mag: src[k].b_mag,
                 q: q_next, r: r_next, neg_q: src[k].neg_q,
                 neg_r: src[k].neg_r, dbz: src[k].dbz}
      : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= stage_d[k];
    end
  end

  // A zero divisor leaves the dividend magnitude as remainder, so the normal
  // remainder sign fixup already restores the original dividend.
  always_comb begin
    rem_mag         = stage_q[STAGES-1].r;
    out_valid       = stage_q[STAGES-1].valid;
    out_div_by_zero = stage_q[STAGES-1].dbz;
    out_quotient    = stage_q[STAGES-1].dbz ? '1
                    : (stage_q[STAGES-1].neg_q ? -stage_q[STAGES-1].q : stage_q[STAGES-1].q);
    out_remainder   = stage_q[STAGES-1].neg_r ? -rem_mag : rem_mag;
  end

endmodule

// File: tb/tb_pipe_divider.sv
// Self-checking bench for pipe_divider: randomized traffic against a plain
// arithmetic reference queue, directed literal cases and a mid-flight reset.
module tb_pipe_divider;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           cyc;
  } obs_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         in_signed;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;
  logic         out_div_by_zero;

  res_t exp_q[$];
  obs_t log_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   rand_ready_en = 1'b0;

  pipe_divider #(
    .WIDTH    (32),
    .STAGES   (8),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_dividend    (in_dividend),
    .in_divisor     (in_divisor),
    .in_signed      (in_signed),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quotient   (out_quotient),
    .out_remainder  (out_remainder),
    .out_div_by_zero(out_div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rand_ready_en) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Reference: plain integer arithmetic, SV division already truncates toward zero.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    res_t   res;
    longint sa;
    longint sb;
    if (b == '0) begin
      res.q = '1; res.r = a; res.dbz = 1'b1;
    end else if (!s) begin
      res.q = a / b; res.r = a % b; res.dbz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res.q = 32'(sa / sb);
      res.r = 32'(sa % sb);
      res.dbz = 1'b0;
    end
    return res;
  endfunction

  // Compare every cycle the output is valid; a stalled result is re-checked
  // against the same queue head, so any drift while stalled is caught.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("quotient", out_quotient, exp_q[0].q);
        checkOutput("remainder", out_remainder, exp_q[0].r);
        checkOutput("div_by_zero", 32'(out_div_by_zero), 32'(exp_q[0].dbz));
        if (out_ready) begin
          log_q.push_back('{q: out_quotient, r: out_remainder, dbz: out_div_by_zero, cyc: cyc});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Called and returns at posedge+1; acc_cyc is the cycle whose edge accepts.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s, output int acc_cyc);
    int budget = 0;
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    in_signed   = s;
    acc_cyc     = -1;
    while (acc_cyc < 0 && budget < 200) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(a, b, s));
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (acc_cyc < 0) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic waitResults(input int n, input string name);
    int budget = 0;
    while (log_q.size() < n && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    checkOutput(name, 32'(log_q.size()), 32'(n));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           acc;
    int           acc2;
    int           n0;
    int           budget;
    int           gap;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;

    reset = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
    in_signed = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_quotient", out_quotient, 32'd0);
    checkOutput("reset_remainder", out_remainder, 32'd0);
    checkOutput("reset_dbz", 32'(out_div_by_zero), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed: unsigned 100/7 and latency");
    n0 = log_q.size();
    applyStimulus(32'd100, 32'd7, 1'b0, acc);
    waitResults(n0 + 1, "result_count_100_7");
    if (log_q.size() > n0) begin
      checkOutput("q_100_7", log_q[n0].q, 32'd14);
      checkOutput("r_100_7", log_q[n0].r, 32'd2);
      checkOutput("dbz_100_7", 32'(log_q[n0].dbz), 32'd0);
      checkOutput("latency_100_7", 32'(log_q[n0].cyc - acc), 32'd8);
    end

    $display("[TB] directed: signed -7/2 and 7/-2 back to back");
    n0 = log_q.size();
    applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, acc);
    applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, acc2);
    waitResults(n0 + 2, "result_count_signed");
    if (log_q.size() > n0 + 1) begin
      checkOutput("q_m7_2", log_q[n0].q, 32'hFFFF_FFFD);
      checkOutput("r_m7_2", log_q[n0].r, 32'hFFFF_FFFF);
      checkOutput("q_7_m2", log_q[n0+1].q, 32'hFFFF_FFFD);
      checkOutput("r_7_m2", log_q[n0+1].r, 32'd1);
      checkOutput("back_to_back_gap", 32'(log_q[n0+1].cyc - log_q[n0].cyc), 32'd1);
      checkOutput("back_to_back_accept", 32'(acc2 - acc), 32'd1);
    end

    $display("[TB] directed: divide by zero and overflow corners");
    n0 = log_q.size();
    applyStimulus(32'h0000_1234, 32'd0, 1'b0, acc);
    applyStimulus(32'h0000_1234, 32'd0, 1'b1, acc);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, acc);
    applyStimulus(32'hFFFF_FFFB, 32'd0, 1'b1, acc);
    waitResults(n0 + 5, "result_count_corners");
    if (log_q.size() > n0 + 4) begin
      checkOutput("q_dbz_unsigned", log_q[n0].q, 32'hFFFF_FFFF);
      checkOutput("r_dbz_unsigned", log_q[n0].r, 32'h0000_1234);
      checkOutput("dbz_unsigned", 32'(log_q[n0].dbz), 32'd1);
      checkOutput("q_dbz_signed", log_q[n0+1].q, 32'hFFFF_FFFF);
      checkOutput("r_dbz_signed", log_q[n0+1].r, 32'h0000_1234);
      checkOutput("dbz_signed", 32'(log_q[n0+1].dbz), 32'd1);
      checkOutput("q_overflow", log_q[n0+2].q, 32'h8000_0000);
      checkOutput("r_overflow", log_q[n0+2].r, 32'd0);
      checkOutput("dbz_overflow", 32'(log_q[n0+2].dbz), 32'd0);
      checkOutput("q_unsigned_big", log_q[n0+3].q, 32'd0);
      checkOutput("r_unsigned_big", log_q[n0+3].r, 32'h8000_0000);
      checkOutput("r_dbz_neg_dividend", log_q[n0+4].r, 32'hFFFF_FFFB);
    end

    $display("[TB] random stream with output backpressure");
    n0 = log_q.size();
    rand_ready_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = ($urandom_range(0, 1) != 0) ? 32'd1 : 32'hFFFF_FFFF;
        2, 3, 4: b = 32'($urandom_range(1, 15));
        default: b = $urandom();
      endcase
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1, 2:    a = 32'($urandom_range(0, 300));
        default: a = $urandom();
      endcase
      s = 1'($urandom_range(0, 1));
      applyStimulus(a, b, s, acc);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    budget = 0;
    while (exp_q.size() > 0 && budget < 1000) begin
      @(posedge clk);
      #1;
      budget++;
    end
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("stream_count", 32'(log_q.size() - n0), 32'd20);
    rand_ready_en = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    $display("[TB] reset with four requests in flight");
    for (int i = 0; i < 4; i++) applyStimulus($urandom(), 32'($urandom_range(1, 100)), 1'b0, acc);
    n0 = log_q.size();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_quotient", out_quotient, 32'd0);
    checkOutput("midreset_remainder", out_remainder, 32'd0);
    checkOutput("midreset_dbz", 32'(out_div_by_zero), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_reset_out_valid", 32'(out_valid), 32'd0);
    reset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("no_stale_results", 32'(log_q.size()), 32'(n0));
    applyStimulus(32'd9, 32'd3, 1'b0, acc);
    waitResults(n0 + 1, "result_count_9_3");
    if (log_q.size() > n0) begin
      checkOutput("q_9_3", log_q[n0].q, 32'd3);
      checkOutput("r_9_3", log_q[n0].r, 32'd0);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
